clk_div_any: RTL

//  Programmable 50%-duty clock divider for any integer N in [1, 2^WIDTH-1].
//  It replaces the separate odd and even dividers in the freq_div tree.
//  N is reloaded glitch-free at output period boundaries through a load handshake.
//  It also provides a period-start tick and a busy flag for the frequency-switch controller.

---
 rtl/clk_div_any.sv | 98 +++++++++
 1 files changed

// File: rtl/clk_div_any.sv
// Programmable 50%-duty clock divider, any N in [1, 2^WIDTH-1].
// N reloads glitch-free at period boundaries via a load handshake.
module clk_div_any #(
  parameter int WIDTH   = 8,
  parameter int RESET_N = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] n_in,
  input  logic             n_load,
  output logic             clk_out,
  output logic             tick,
  output logic [WIDTH-1:0] n_active,
  output logic             busy,
  output logic             n_err
);

  localparam logic [WIDTH-1:0] RST_N = WIDTH'(RESET_N);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] nact_q, nact_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             p_q, p_d;
  logic             q_q;
  logic             run_q, run_d;
  logic             tick_q, tick_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             load_ok, wrap, apply;
  logic [WIDTH:0]   half;

  always_comb begin
    load_ok = n_load && (n_in != '0);
    wrap    = (cnt_q == nact_q - 1'b1);
    // disabled: pending N applies at once, no boundary needed
    apply   = busy_q && (!enable || (run_q && wrap));
    nact_d  = apply ? pend_q : nact_q;
    pend_d  = load_ok ? n_in : pend_q;
    busy_d  = load_ok || (busy_q && !apply);
    err_d   = n_load && (n_in == '0);
    run_d   = enable;
    cnt_d   = cnt_q + 1'b1;
    if (!enable || !run_q || wrap) begin
      cnt_d = '0;
    end
    half    = ({1'b0, nact_d} + (WIDTH+1)'(1)) >> 1;
    p_d     = enable && ({1'b0, cnt_d} < half);
    tick_d  = enable && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      nact_q <= RST_N;
      pend_q <= '0;
      p_q    <= 1'b0;
      run_q  <= 1'b0;
      tick_q <= 1'b0;
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      nact_q <= nact_d;
      pend_q <= pend_d;
      p_q    <= p_d;
      run_q  <= run_d;
      tick_q <= tick_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // half-cycle delayed copy gives odd-N 50% duty
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      q_q <= 1'b0;
    end else begin
      q_q <= p_q;
    end
  end

  always_comb begin
    if (nact_q == WIDTH'(1)) begin
      clk_out = clk & enable;
    end else if (nact_q[0]) begin
      clk_out = p_q & q_q;
    end else begin
      clk_out = p_q;
    end
  end

  assign tick     = tick_q & enable;
  assign n_active = nact_q;
  assign busy     = busy_q;
  assign n_err    = err_q;

endmodule
